pixel_writeback_arbiter: RTL and testbench
==========================================

Name: pixel_writeback_arbiter

Overview:
- Collects finished pixels from the NUM_CORES ray_unit cores and writes them into the frame-buffer BRAM write port.
- Round-robin arbitrates among cores using a valid/ack handshake.
- Converts (hcount, vcount) to a linear BRAM address.
- Counts written pixels per frame and signals frame completion back to the work dispatcher, so a new frame is started only after every pixel has landed in memory.

Parameters:
- NUM_CORES, 4, number of ray cores (requesters).
- DISPLAY_WIDTH, 320, pixels per row.
- DISPLAY_HEIGHT, 240, rows per frame.
- H_BITS, 9, hcount width.
- V_BITS, 8, vcount width.
- COLOR_BITS, 4, pixel colour width.
- ADDR_BITS, 17, BRAM address width; must satisfy 2^ADDR_BITS >= DISPLAY_WIDTH*DISPLAY_HEIGHT.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- frame_start_in  input  1  one-cycle pulse that opens collection for a new frame.
- core_valid_in  input  NUM_CORES  per-core result-valid flag.
- core_hcount_in  input  NUM_CORES*H_BITS  packed pixel x coordinates; core i occupies bits [i*H_BITS +: H_BITS].
- core_vcount_in  input  NUM_CORES*V_BITS  packed pixel y coordinates, same packing.
- core_color_in  input  NUM_CORES*COLOR_BITS  packed pixel colours, same packing.
- core_ack_out  output  NUM_CORES  one-hot grant; a result is transferred at the clock edge where valid and ack are both high.
- bram_addr_out  output  ADDR_BITS  write address.
- bram_data_out  output  COLOR_BITS  write data.
- bram_we_out  output  1  write enable.
- pixels_written_out  output  ADDR_BITS+1  in-range pixels accepted this frame.
- busy_out  output  1  high while the state is not IDLE.
- frame_done_out  output  1  one-cycle pulse issued with the final pixel write.
- error_out  output  1  sticky error flag.

Behaviour:
- Clocking and reset: one clock domain, clk_in. rst_in is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer 0, so core 0 has highest priority first.
  - Pipeline valid bits cleared.
- Reset mid-frame: abandons the frame and drops any in-flight write (no bram_we on the following cycle).
- States:
  - IDLE -> COLLECT on frame_start_in. The pixel counter clears on that same edge.
  - COLLECT -> DRAIN on the edge where the accepted count reaches DISPLAY_WIDTH*DISPLAY_HEIGHT.
  - DRAIN -> IDLE once the final write has been issued. frame_done_out is high during that write cycle.
- frame_start_in is ignored outside IDLE.
- Arbitration:
  - core_ack_out is combinational.
  - Zero in IDLE and DRAIN. Cores are back-pressured and must hold valid and data stable until acked.
  - In COLLECT, grant exactly one valid core: the first valid core at or after index (last_grant+1) mod NUM_CORES.
  - last_grant updates only on an actual transfer.
  - No valid cores means ack is 0 and the pointer holds.
  - At most one transfer per cycle.
- Pipeline (latency 2 cycles from handshake edge to bram_we_out):
  - Stage 1 registers the granted core's hcount, vcount and colour, plus a valid bit.
  - Stage 2 registers bram_addr_out = vcount*DISPLAY_WIDTH + hcount (full-width arithmetic, truncated to ADDR_BITS), bram_data_out and bram_we_out.
  - Throughput is one pixel per cycle with continuous valids.
  - bram_addr_out and bram_data_out hold their last values when bram_we_out is 0.
- Range check:
  - A transfer with hcount >= DISPLAY_WIDTH or vcount >= DISPLAY_HEIGHT is still acked (the core is released).
  - It is dropped: no write and no count.
  - It sets error_out.
- Counting:
  - pixels_written_out increments at handshake time for in-range pixels only, so granting stops exactly at the frame total.
  - Duplicate coordinates are not detected; each is counted and written.
- error_out is sticky until rst_in or the next accepted frame_start_in.
- Simultaneous events:
  - The last in-range accept while another core is valid: the other core receives no ack in that cycle or afterwards, and waits for the next frame.
  - frame_start_in on the same cycle as the DRAIN->IDLE transition is ignored; the dispatcher must pulse it after frame_done_out.

Test Plan:
Benches run with NUM_CORES=4, DISPLAY_WIDTH=4, DISPLAY_HEIGHT=2, ADDR_BITS=3.
1. Reset, then cores 0-3 valid with no frame_start -> core_ack_out stays 4'b0000, busy_out=0, bram_we_out=0.
2. Round-robin fairness: frame_start, then all 4 cores hold valid -> acks 0001,0010,0100,1000,0001,... on consecutive cycles.
3. Write mapping and latency: core 2 sends (h=3,v=1,c=0xA), acked at edge t -> bram_we_out=1, addr=7, data=0xA at t+2.
4. Frame completion: 8 in-range pixels from mixed cores -> pixels_written_out=8, frame_done_out pulses with the 8th write, a still-valid core gets no ack, state returns to IDLE.
5. Out-of-range: core 1 sends (h=4,v=0) -> acked, no write, count unchanged, error_out=1 until next frame_start.
6. Mid-frame reset after 3 accepts with one write in flight -> next cycle all outputs 0, no bram_we; after reset, frame_start gives first grant to core 0.

Source files
------------

// File: rtl/pixel_writeback_arbiter.sv
// Round-robin collector of finished ray-core pixels into the frame-buffer write port; 2-cycle handshake-to-write latency.
// Cores hold valid/data until acked; no acks outside COLLECT or once the frame's pixel total has been accepted.
module pixel_writeback_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int COLOR_BITS     = 4,
  parameter int ADDR_BITS      = 17
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           frame_start_in,
  input  logic [NUM_CORES-1:0]           core_valid_in,
  input  logic [NUM_CORES*H_BITS-1:0]    core_hcount_in,
  input  logic [NUM_CORES*V_BITS-1:0]    core_vcount_in,
  input  logic [NUM_CORES*COLOR_BITS-1:0] core_color_in,
  output logic [NUM_CORES-1:0]           core_ack_out,
  output logic [ADDR_BITS-1:0]           bram_addr_out,
  output logic [COLOR_BITS-1:0]          bram_data_out,
  output logic                           bram_we_out,
  output logic [ADDR_BITS:0]             pixels_written_out,
  output logic                           busy_out,
  output logic                           frame_done_out,
  output logic                           error_out
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] FRAME_TOTAL = CNT_W'(DISPLAY_WIDTH * DISPLAY_HEIGHT);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  typedef struct packed {
    logic [H_BITS-1:0]     h;
    logic [V_BITS-1:0]     v;
    logic [COLOR_BITS-1:0] c;
  } pix_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  int                cand_i;
  logic              grant_found;
  pix_t              sel_pix;
  pix_t              s1_pix_q;
  logic              s1_vld_q;
  logic              in_range;
  logic              accept_ok;
  logic              frame_open;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;

  // Search starts at rr_ptr_q, which already holds (last_grant + 1) mod NUM_CORES.
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    cand_i       = 0;
    core_ack_out = '0;
    if (state_q == COLLECT) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        cand_i = int'(rr_ptr_q) + k;
        if (cand_i >= NUM_CORES) cand_i = cand_i - NUM_CORES;
        cand = PTR_W'(cand_i);
        if (!grant_found && core_valid_in[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
      core_ack_out[grant_idx] = grant_found;
    end
  end

  always_comb begin
    sel_pix.h  = core_hcount_in[int'(grant_idx)*H_BITS +: H_BITS];
    sel_pix.v  = core_vcount_in[int'(grant_idx)*V_BITS +: V_BITS];
    sel_pix.c  = core_color_in[int'(grant_idx)*COLOR_BITS +: COLOR_BITS];
    in_range   = (32'(sel_pix.h) < 32'(DISPLAY_WIDTH)) && (32'(sel_pix.v) < 32'(DISPLAY_HEIGHT));
    accept_ok  = grant_found && in_range;
    cnt_inc    = cnt_q + CNT_W'(1);
    frame_open = (state_q == IDLE) && frame_start_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start_in) state_d = COLLECT;
      COLLECT: if (accept_ok && (cnt_inc == FRAME_TOTAL)) state_d = DRAIN;
      // Only the frame's final pixel can be in stage 1 while draining.
      DRAIN:   if (s1_vld_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      s1_vld_q       <= 1'b0;
      s1_pix_q       <= '0;
      bram_addr_out  <= '0;
      bram_data_out  <= '0;
      bram_we_out    <= 1'b0;
      frame_done_out <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      if (grant_found)
        rr_ptr_q <= (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);

      if (frame_open)     cnt_q <= '0;
      else if (accept_ok) cnt_q <= cnt_inc;

      // Out-of-range transfers are released but never reach the write pipeline.
      if (frame_open)                    error_out <= 1'b0;
      else if (grant_found && !in_range) error_out <= 1'b1;

      s1_vld_q <= accept_ok;
      if (accept_ok) s1_pix_q <= sel_pix;

      bram_we_out <= s1_vld_q;
      if (s1_vld_q) begin
        bram_addr_out <= ADDR_BITS'(32'(s1_pix_q.v) * 32'(DISPLAY_WIDTH) + 32'(s1_pix_q.h));
        bram_data_out <= s1_pix_q.c;
      end
      frame_done_out <= (state_q == DRAIN) && s1_vld_q;
    end
  end

  assign pixels_written_out = cnt_q;
  assign busy_out           = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_writeback_arbiter.sv
// Randomized and directed bench for pixel_writeback_arbiter against a cycle-scheduled reference model.
module tb_pixel_writeback_arbiter;
  localparam int NC = 4, W = 4, H = 2, HB = 9, VB = 8, CB = 4, AB = 3;
  localparam int TOTAL = W * H;
  localparam int MAXC  = 4000;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in;
  logic          frame_start_in;
  logic [NC-1:0] vld;
  logic [HB-1:0] hh [NC];
  logic [VB-1:0] vv [NC];
  logic [CB-1:0] cc [NC];
  logic [NC*HB-1:0] h_bus;
  logic [NC*VB-1:0] v_bus;
  logic [NC*CB-1:0] c_bus;

  logic [NC-1:0] dut_ack;
  logic [AB-1:0] dut_addr;
  logic [CB-1:0] dut_data;
  logic          dut_we;
  logic [AB:0]   dut_cnt;
  logic          dut_busy, dut_done, dut_err;

  for (genvar gi = 0; gi < NC; gi++) begin : g_pack
    assign h_bus[gi*HB +: HB] = hh[gi];
    assign v_bus[gi*VB +: VB] = vv[gi];
    assign c_bus[gi*CB +: CB] = cc[gi];
  end

  pixel_writeback_arbiter #(
    .NUM_CORES(NC), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
    .H_BITS(HB), .V_BITS(VB), .COLOR_BITS(CB), .ADDR_BITS(AB)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .core_valid_in(vld), .core_hcount_in(h_bus), .core_vcount_in(v_bus),
    .core_color_in(c_bus), .core_ack_out(dut_ack), .bram_addr_out(dut_addr),
    .bram_data_out(dut_data), .bram_we_out(dut_we), .pixels_written_out(dut_cnt),
    .busy_out(dut_busy), .frame_done_out(dut_done), .error_out(dut_err)
  );

  // Reference model: frame open flag, accepted count, last granted core, and
  // expected writes scheduled by absolute cycle number.
  bit            m_open, m_err;
  int            m_cnt, m_last, m_busy_until;
  logic [NC-1:0] m_ack;
  bit            s_we   [MAXC];
  bit            s_done [MAXC];
  int            s_addr [MAXC];
  int            s_data [MAXC];
  int            cur_addr, cur_data;
  int            cyc, n_chk, n_err;
  bit            pend [NC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] model_ack();
    logic [NC-1:0] a = '0;
    if (m_open)
      for (int k = 0; k < NC; k++) begin
        int i = (m_last + 1 + k) % NC;
        if (vld[i] && a == '0) a[i] = 1'b1;
      end
    return a;
  endfunction

  // Called at a negedge with inputs applied: compare, advance model over the edge.
  task automatic step();
    logic [NC-1:0] ea;
    bit idle;
    #1;
    if (s_we[cyc]) begin
      cur_addr = s_addr[cyc];
      cur_data = s_data[cyc];
    end
    ea = model_ack();
    chk("ack",   dut_ack,  ea);
    chk("we",    dut_we,   s_we[cyc]);
    chk("done",  dut_done, s_done[cyc]);
    chk("busy",  dut_busy, m_open || cyc < m_busy_until);
    chk("count", dut_cnt,  m_cnt);
    chk("error", dut_err,  m_err);
    chk("addr",  dut_addr, cur_addr);
    chk("data",  dut_data, cur_data);
    m_ack = ea;
    if (rst_in) begin
      m_open = 0; m_cnt = 0; m_last = NC - 1; m_err = 0; m_busy_until = 0;
      s_we[cyc+1] = 0; s_we[cyc+2] = 0; s_done[cyc+1] = 0; s_done[cyc+2] = 0;
      cur_addr = 0; cur_data = 0;
    end else begin
      idle = !m_open && cyc >= m_busy_until;
      for (int i = 0; i < NC; i++)
        if (ea[i]) begin
          m_last = i;
          if (int'(hh[i]) < W && int'(vv[i]) < H) begin
            m_cnt++;
            s_we[cyc+2]   = 1;
            s_addr[cyc+2] = int'(vv[i]) * W + int'(hh[i]);
            s_data[cyc+2] = int'(cc[i]);
            if (m_cnt == TOTAL) begin
              m_open = 0;
              s_done[cyc+2] = 1;
              m_busy_until = cyc + 2;
            end
          end else begin
            m_err = 1;
          end
        end
      if (idle && frame_start_in) begin
        m_open = 1; m_cnt = 0; m_err = 0;
      end
    end
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic set_pix(input int i, input int h, input int v, input int c);
    hh[i] = HB'(h); vv[i] = VB'(v); cc[i] = CB'(c);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    m_open = 0; m_err = 0; m_cnt = 0; m_last = NC - 1; m_busy_until = 0;
    cur_addr = 0; cur_data = 0; m_ack = '0;
    rst_in = 1; frame_start_in = 0; vld = '0;
    for (int i = 0; i < NC; i++) begin set_pix(i, 0, 0, 0); pend[i] = 0; end
    repeat (2) @(negedge clk_in);
    step();
    rst_in = 0;

    // No frame open: valid cores receive nothing.
    for (int i = 0; i < NC; i++) set_pix(i, i, 0, i);
    vld = '1;
    repeat (3) begin
      step();
      chk("idle_ack", dut_ack, 0);
      chk("idle_busy", dut_busy, 0);
      chk("idle_we", dut_we, 0);
    end

    // Round-robin, write mapping and frame completion.
    frame_start_in = 1; vld = '0; step(); frame_start_in = 0;
    set_pix(2, 3, 1, 'hA);
    vld = '1;
    for (int k = 0; k < TOTAL; k++) begin
      #1;
      chk("rr_ack", dut_ack, 1 << (k % NC));
      if (k == 4) begin
        chk("map_we", dut_we, 1);
        chk("map_addr", dut_addr, 7);
        chk("map_data", dut_data, 'hA);
      end
      step();
      set_pix(k % NC, k % NC, 1, k + 4);
    end
    chk("total_cnt", dut_cnt, TOTAL);
    chk("drain_busy", dut_busy, 1);
    chk("drain_ack", dut_ack, 0);
    step();
    chk("final_we", dut_we, 1);
    chk("final_done", dut_done, 1);
    chk("final_busy", dut_busy, 0);
    chk("final_ack", dut_ack, 0);
    step();
    chk("done_pulse", dut_done, 0);

    // Out-of-range transfer is acked, dropped and flagged.
    vld = '0; frame_start_in = 1; step(); frame_start_in = 0;
    set_pix(1, 4, 0, 5); vld = 4'b0010;
    #1 chk("oor_ack", dut_ack, 4'b0010);
    step(); vld = '0;
    chk("oor_err", dut_err, 1);
    chk("oor_cnt", dut_cnt, 0);
    step();
    chk("oor_we", dut_we, 0);
    repeat (3) step();
    chk("oor_sticky", dut_err, 1);
    for (int i = 0; i < NC; i++) set_pix(i, i, 0, 3);
    vld = '1;
    for (int n = 0; n < 60 && (m_open || cyc < m_busy_until); n++) step();
    vld = '0; frame_start_in = 1; step(); frame_start_in = 0;
    chk("err_clear", dut_err, 0);

    // Mid-frame reset with writes in flight.
    vld = '1;
    repeat (3) step();
    vld = '0; rst_in = 1; step(); rst_in = 0;
    chk("rst_we", dut_we, 0);
    chk("rst_cnt", dut_cnt, 0);
    chk("rst_busy", dut_busy, 0);
    chk("rst_addr", dut_addr, 0);
    frame_start_in = 1; step(); frame_start_in = 0;
    vld = '1;
    #1 chk("rst_first_grant", dut_ack, 4'b0001);
    step();

    // Random traffic: cores hold each pixel until the model says it was acked.
    for (int i = 0; i < NC; i++) pend[i] = 0;
    while (cyc < MAXC - 100) begin
      rst_in = ($urandom_range(0, 399) == 0);
      frame_start_in = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NC; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          set_pix(i, ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3)),
                     ($urandom_range(0, 15) == 0) ? 2 : int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)));
        end
        vld[i] = pend[i];
      end
      step();
      for (int i = 0; i < NC; i++) if (m_ack[i]) pend[i] = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
